spi_word_rx: RTL
================

Name: spi_word_rx

Overview:
- SPI mode-0 slave front end. Deserialises MOSI into WORD_W-bit words, MSB first, and buffers them in a small FIFO.
- Presents the words on a valid/ready stream to the downstream command/vertex decoder. That decoder consumes (x,y) coordinate words such as 0x0064.
- SCLK, CS and MOSI are asynchronous to the system clock. They are synchronised and edge-detected in the system clock domain, with no SCLK clock domain.

Parameters:
- WORD_W, 16, bits per received word.
- FIFO_DEPTH, 4, word buffer entries; must be a power of two, ≥2.
- SYNC_STAGES, 2, flip-flop stages on each SPI input; must be ≥2.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- io_spi_sclk  in  1  SPI clock from the MCU. It must stay ≤ clock/8.
- io_spi_cs  in  1  chip select, active low.
- io_spi_mosi  in  1  serial data in.
- io_spi_miso  out  1  serial data out (see Optional Feature).
- out_data  out  WORD_W  head-of-FIFO word.
- out_first  out  1  head word is the first word since CS fell.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head word.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- frame_err  out  1  sticky: CS rose with a partial word in the shifter.
- clear_err  in  1  synchronous clear of overflow and frame_err.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_first=0, overflow=0, frame_err=0, io_spi_miso=0. Reset also clears the FIFO pointers, the shifter, the bit counter and first_pending, and puts the FSM in IDLE.
- Reset is asynchronous and takes effect at any time. Asserting it mid-word discards the partial word and all buffered words.
- Synchronisers: each of SCLK, CS and MOSI passes through SYNC_STAGES flops. A rising edge is sclk_s & ~sclk_d, using one extra delay flop. Falling edges and CS edges are derived the same way.
- FSM has two states:
  - IDLE: entered on reset or on synchronised CS high. The bit counter is held at 0.
  - IDLE→ACTIVE on CS falling. Sets first_pending=1.
  - ACTIVE: on each SCLK rising edge, shifter <= {shifter[WORD_W-2:0], mosi_s} and the bit counter increments.
  - When the counter reaches WORD_W-1 and an SCLK rising edge occurs, the FSM pushes {first_pending, completed word}, clears the counter and clears first_pending.
  - ACTIVE→IDLE on CS rising. If the bit counter ≠ 0, frame_err<=1 and the partial word is discarded. A completed word is never lost to CS rising.
- Latency: the pushed word appears at out_data/out_valid on the clock cycle after the push. From the last SCLK rising edge at the pin to out_valid this is SYNC_STAGES+2 clocks.
- FIFO:
  - Pop when out_valid & out_ready.
  - A push is accepted when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow<=1 and FIFO contents are unchanged.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- out_data/out_first are driven from the head entry and stay stable while out_valid & ~out_ready.
- clear_err clears both sticky flags in the next cycle. A new error event in the same cycle as clear_err wins, so the flag stays 1.
- SCLK edges while CS is high are ignored.

Optional Feature:
- Macro SPI_MISO_ECHO_EN.
- Defined:
  - A WORD_W tx shifter loads the most recently completed word at each word boundary and at CS falling. At CS falling it loads 0 if no word has been received since reset.
  - MISO is updated on synchronised SCLK falling edges, MSB first, so the MCU reads back word n-1 while sending word n.
  - io_spi_miso=0 while CS is high.
- Undefined: io_spi_miso is tied to 0 and no tx shifter is instantiated.

Decomposition:
- Package spi_rx_pkg holds:
  - localparam WORD_W_DEF=16;
  - typedef enum logic {IDLE, ACTIVE} spi_state_t;
  - typedef struct packed {logic first; logic [15:0] data;} spi_word_t.
- One sub-module, sync_fifo (parameters WIDTH and DEPTH, with push/pop/full/empty/count), instantiated with WIDTH=WORD_W+1.
- Synchronisers stay inline.

Test Plan:
- CS low, send 0x0000, 0x0064, 0x0064 at SCLK period 500 ns, out_ready=1 → three pulses: 0x0000 with out_first=1, then 0x0064 and 0x0064 with out_first=0; no error flags.
- out_ready=0, send 5 words 0x0001..0x0005 → out_valid holds 0x0001; overflow=1 after word 5. Draining yields 0x0001..0x0004 only.
- Send 7 bits, then raise CS → frame_err=1 and nothing is pushed. Pulse clear_err → frame_err=0. Drop CS and send 0x00C8 → 0x00C8 with out_first=1.
- FIFO full with out_ready=1 asserted in the same cycle as the 5th push completes → no overflow, and word order is preserved.
- Assert reset mid-word and also with 2 words buffered → out_valid=0 within the same cycle. The next frame starts clean with out_first=1.
- With SPI_MISO_ECHO_EN defined, send 0x0064 then 0x00C8 → MISO during the second word shifts out 0x0064 MSB first. Without the macro, MISO stays 0 throughout.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_rx_pkg
// Shared types and defaults for the SPI word receiver.
//   WORD_W_DEF  : default received word width
//   spi_state_t : receiver FSM states (IDLE, ACTIVE)
//   spi_word_t  : FIFO entry layout {first, data} at the default width
// -----------------------------------------------------------------------------
package spi_rx_pkg;

  localparam int unsigned WORD_W_DEF = 16;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_t;

  typedef struct packed {
    logic                  first;
    logic [WORD_W_DEF-1:0] data;
  } spi_word_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with asynchronous active-high reset. DEPTH must be a
// power of two so the pointers wrap naturally.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_push/i_data : write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   i_pop         : read request; ignored while empty
//   o_data        : head entry (zero while empty)
//   o_full/o_empty/o_count : occupancy status
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/spi_word_rx.sv
// -----------------------------------------------------------------------------
// spi_word_rx
// SPI mode-0 slave front end. SCLK/CS/MOSI are synchronised into the system
// clock domain and edge-detected; MOSI is shifted MSB first into WORD_W-bit
// words which are buffered in a FIFO and presented on a valid/ready stream.
// Optional build macro SPI_MISO_ECHO_EN: echo the previously completed word
// on MISO (otherwise MISO is tied low).
// Ports:
//   clock, reset            : system clock, asynchronous active-high reset
//   io_spi_sclk/cs/mosi     : asynchronous SPI inputs (CS active low)
//   io_spi_miso             : serial data out
//   out_data/out_first      : head word and "first word of frame" flag
//   out_valid/out_ready     : stream handshake
//   overflow/frame_err      : sticky error flags, cleared by clear_err
// -----------------------------------------------------------------------------
module spi_word_rx
  import spi_rx_pkg::*;
#(
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_spi_sclk,
  input  logic              io_spi_cs,
  input  logic              io_spi_mosi,
  output logic              io_spi_miso,
  output logic [WORD_W-1:0] out_data,
  output logic              out_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clear_err
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sclk_rise;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;

  // CS resets to its idle (high) level so a CS already low when reset
  // releases is still seen as a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], io_spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_spi_mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  spi_state_t        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-1:0] r_shift;
  logic              r_first_pending;
  logic              r_push;
  logic [WORD_W:0]   r_push_data;
  logic              r_frame_err;

  logic [WORD_W-1:0] w_shift_next;
  logic              w_last_bit;
  logic              w_partial;

  assign w_shift_next = {r_shift[WORD_W-2:0], w_mosi_s};
  assign w_last_bit   = w_sclk_rise && (r_bit_cnt == CNT_W'(WORD_W - 1));
  // A word completing on the same cycle CS rises is pushed, not flagged.
  assign w_partial    = ((r_bit_cnt != '0) || w_sclk_rise) && !w_last_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_first_pending <= 1'b0;
      r_push          <= 1'b0;
      r_push_data     <= '0;
      r_frame_err     <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (clear_err) r_frame_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          if (w_cs_fall) begin
            r_state         <= ACTIVE;
            r_first_pending <= 1'b1;
            r_shift         <= '0;
          end
        end
        ACTIVE: begin
          if (w_sclk_rise) begin
            r_shift <= w_shift_next;
            if (w_last_bit) begin
              r_push          <= 1'b1;
              r_push_data     <= {r_first_pending, w_shift_next};
              r_bit_cnt       <= '0;
              r_first_pending <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          if (w_cs_rise) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            // Later assignment wins over clear_err above.
            if (w_partial) r_frame_err <= 1'b1;
          end
        end
      endcase
    end
  end

  assign frame_err = r_frame_err;

  // ---------------------------------------------------------------------------
  // Word FIFO and overflow flag
  // ---------------------------------------------------------------------------
  logic [WORD_W:0]              w_head;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  w_fifo_count;
  logic                         w_pop;
  logic                         w_drop;
  logic                         r_overflow;
  logic                         w_unused_count;

  assign w_unused_count = ^w_fifo_count;

  sync_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign out_valid = ~w_fifo_empty;
  assign out_data  = w_head[WORD_W-1:0];
  assign out_first = w_head[WORD_W];
  assign w_pop     = out_valid & out_ready;
  assign w_drop    = r_push & w_fifo_full & ~w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_err) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;

  // ---------------------------------------------------------------------------
  // Optional MISO echo of the previously completed word
  // ---------------------------------------------------------------------------
`ifdef SPI_MISO_ECHO_EN
  logic              w_sclk_fall;
  logic [WORD_W-1:0] r_tx_shift;
  logic [WORD_W-1:0] r_last_word;
  logic              r_miso;

  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;

  // The MSB is presented as soon as a word is loaded; each SCLK falling edge
  // then advances one bit, so the boundary load lines up with the next word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_shift  <= '0;
      r_last_word <= '0;
      r_miso      <= 1'b0;
    end else begin
      if (r_push) r_last_word <= r_push_data[WORD_W-1:0];
      if (w_cs_s) begin
        r_miso <= 1'b0;
      end else if (w_cs_fall) begin
        r_miso     <= r_last_word[WORD_W-1];
        r_tx_shift <= {r_last_word[WORD_W-2:0], 1'b0};
      end else if (w_sclk_fall && (r_state == ACTIVE)) begin
        r_miso     <= r_tx_shift[WORD_W-1];
        r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
      end
      if (r_push) r_tx_shift <= r_push_data[WORD_W-1:0];
    end
  end

  assign io_spi_miso = r_miso;
`else
  assign io_spi_miso = 1'b0;
`endif

endmodule
